sram_master: RTL
================

SRAM_MASTER -- requirements
Module: sram_master

Interface
REQ-001 SHALL have parameter ID, default 4'd0, giving the constant value driven on o_arid and o_awid.
REQ-002 SHALL have port i_aclk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port i_areset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have the command ports i_cmd_valid in 1, i_cmd_write in 1 (1 = write), i_cmd_addr in 8 (byte address), i_cmd_len in 8 (beats-1), o_cmd_ready out 1.
REQ-005 SHALL have the write-stream ports i_wr_data in 64, i_wr_valid in 1, o_wr_ready out 1.
REQ-006 SHALL have the read-stream ports o_rd_data out 64, o_rd_valid out 1, o_rd_last out 1, i_rd_ready in 1.
REQ-007 SHALL have the status ports o_done out 1 (one-cycle completion pulse) and o_err out 1 (valid with o_done).
REQ-008 SHALL have the AXI4 read-address ports o_arid out 4, o_araddr out 8, o_arlen out 8, o_arsize out 3, o_arburst out 2, o_arvalid out 1, i_arready in 1.
REQ-009 SHALL have the AXI4 read-data ports i_rdata in 64, i_rresp in 2, i_rlast in 1, i_rvalid in 1, o_rready out 1.
REQ-010 SHALL have the AXI4 write-address ports o_awid out 4, o_awaddr out 8, o_awlen out 8, o_awsize out 3, o_awburst out 2, o_awvalid out 1, i_awready in 1.
REQ-011 SHALL have the AXI4 write-data ports o_wdata out 64, o_wstrb out 8, o_wlast out 1, o_wvalid out 1, i_wready in 1.
REQ-012 SHALL have the AXI4 write-response ports i_bresp in 2, i_bvalid in 1, o_bready out 1.

Function
REQ-013 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE; unused encodings SHALL go to IDLE.
REQ-014 SHALL drive o_cmd_ready=1 only in IDLE; command accepted on i_cmd_valid && o_cmd_ready, latching addr and len, clearing beat counter and error flag.
REQ-015 SHALL go from IDLE to WR_ADDR when i_cmd_write=1, else to RD_ADDR, on the cycle after acceptance.
REQ-016 SHALL drive o_arsize/o_awsize=3'b011, o_arburst/o_awburst=2'b01 (INCR), o_ar/awaddr=latched addr, o_ar/awlen=latched len.
REQ-017 SHALL hold o_arvalid=1 for the whole of RD_ADDR, with address fields stable until i_arready; handshake -> RD_DATA.
REQ-018 In RD_DATA: o_rready=i_rd_ready, o_rd_valid=i_rvalid, o_rd_data=i_rdata, o_rd_last=i_rlast (combinational pass-through); zero/deasserted in other states.
REQ-019 SHALL increment the 8-bit beat counter on each R handshake; on the handshake where counter==len -> DONE.
REQ-020 SHALL set the error flag on any R beat with i_rresp!=2'b00, or when i_rlast disagrees with (counter==len).
REQ-021 SHALL hold o_awvalid=1 for the whole of WR_ADDR until i_awready; handshake -> WR_DATA.
REQ-022 In WR_DATA: o_wvalid=i_wr_valid, o_wr_ready=i_wready, o_wdata=i_wr_data, o_wstrb=8'hFF, o_wlast=(counter==len); otherwise deasserted.
REQ-023 SHALL count W handshakes; on the handshake with o_wlast=1 -> WR_RESP.
REQ-024 SHALL drive o_bready=1 in WR_RESP; on i_bvalid set the error flag if i_bresp!=2'b00, then -> DONE.
REQ-025 DONE SHALL last exactly one cycle with o_done=1 and o_err=error flag, then -> IDLE; o_err SHALL be 0 outside DONE.
REQ-026 SHALL allow len=0 (single beat): last beat on first handshake; len=255 SHALL give 256 beats without counter overflow affecting termination.
REQ-027 SHALL not accept a new command until DONE completes; back-to-back commands SHALL give cmd acceptance at minimum every (beats+3) cycles.

Reset
REQ-028 While i_areset=1 at a clock edge, the FSM SHALL enter IDLE, with counter=0, error flag=0, latched addr/len=0, and all valid/ready/done/err outputs 0 except o_cmd_ready=1 after release.
REQ-029 Reset asserted mid-burst SHALL abandon the transfer immediately, with no o_done pulse.

Verification
REQ-030 Read len=3 addr=8'h10, slave rresp=0 with rlast on beat 4 -> 4 rd beats, o_rd_last on the 4th, o_done=1 and o_err=0.
REQ-031 Write len=0 addr=8'h20, data 64'hDEAD_BEEF -> one W beat with o_wlast=1, wstrb=8'hFF, bresp=0 -> o_done=1, o_err=0.
REQ-032 Read with i_arready delayed 5 cycles and i_rd_ready toggling -> o_arvalid held stable for 5 cycles, no beat lost or duplicated.
REQ-033 Write with bresp=2'b10 -> o_done=1 and o_err=1; read with rlast early on beat 2 of len=3 -> o_err=1.
REQ-034 Reset asserted during RD_DATA beat 2 -> next cycle FSM in IDLE, o_arvalid=o_rready=0, no o_done, and a new command accepted after reset release.

Source files
------------

// File: rtl/sram_master_if.sv
// AXI4 master-side bus bundle for sram_master: read address/data, write
// address/data/response channels. Signal names carry the bus-facing
// direction as seen from the master.
interface sram_master_if;
    // read address channel
    logic [3:0]  o_arid;
    logic [7:0]  o_araddr;
    logic [7:0]  o_arlen;
    logic [2:0]  o_arsize;
    logic [1:0]  o_arburst;
    logic        o_arvalid;
    logic        i_arready;
    // read data channel
    logic [63:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rlast;
    logic        i_rvalid;
    logic        o_rready;
    // write address channel
    logic [3:0]  o_awid;
    logic [7:0]  o_awaddr;
    logic [7:0]  o_awlen;
    logic [2:0]  o_awsize;
    logic [1:0]  o_awburst;
    logic        o_awvalid;
    logic        i_awready;
    // write data channel
    logic [63:0] o_wdata;
    logic [7:0]  o_wstrb;
    logic        o_wlast;
    logic        o_wvalid;
    logic        i_wready;
    // write response channel
    logic [1:0]  i_bresp;
    logic        i_bvalid;
    logic        o_bready;

    modport master (
        output o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid,
        input  i_arready,
        input  i_rdata, i_rresp, i_rlast, i_rvalid,
        output o_rready,
        output o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid,
        input  i_awready,
        output o_wdata, o_wstrb, o_wlast, o_wvalid,
        input  i_wready,
        input  i_bresp, i_bvalid,
        output o_bready
    );

    modport slave (
        input  o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid,
        output i_arready,
        output i_rdata, i_rresp, i_rlast, i_rvalid,
        input  o_rready,
        input  o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid,
        output i_awready,
        input  o_wdata, o_wstrb, o_wlast, o_wvalid,
        output i_wready,
        output i_bresp, i_bvalid,
        input  o_bready
    );
endinterface

// File: rtl/sram_master.sv
// sram_master: turns one command (addr, len, direction) into a single AXI4
// INCR burst of 64-bit beats. Read data and write data are streamed straight
// through between the client stream ports and the AXI channels; a completion
// pulse with an error flag closes every transfer.
module sram_master #(
    parameter logic [3:0] ID = 4'd0
) (
    input  logic        i_aclk,
    input  logic        i_areset,
    // command
    input  logic        i_cmd_valid,
    input  logic        i_cmd_write,
    input  logic [7:0]  i_cmd_addr,
    input  logic [7:0]  i_cmd_len,
    output logic        o_cmd_ready,
    // write stream
    input  logic [63:0] i_wr_data,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    // read stream
    output logic [63:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_rd_last,
    input  logic        i_rd_ready,
    // status
    output logic        o_done,
    output logic        o_err,
    // AXI4 bus
    sram_master_if.master axi
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] addr;
    logic [7:0] len;
    logic [7:0] cnt;
    logic       err;

    logic cmd_fire, r_fire, w_fire, b_fire, last_beat;

    // Ready is held off while reset is asserted so nothing is accepted then.
    assign o_cmd_ready = (state == IDLE) && !i_areset;
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;
    assign last_beat   = (cnt == len);
    assign r_fire      = (state == RD_DATA) && axi.i_rvalid && i_rd_ready;
    assign w_fire      = (state == WR_DATA) && i_wr_valid && axi.i_wready;
    assign b_fire      = (state == WR_RESP) && axi.i_bvalid;

    // Address channels: fixed INCR bursts of 8-byte beats from the latched command.
    assign axi.o_arid    = ID;
    assign axi.o_araddr  = addr;
    assign axi.o_arlen   = len;
    assign axi.o_arsize  = 3'b011;
    assign axi.o_arburst = 2'b01;
    assign axi.o_arvalid = (state == RD_ADDR);

    assign axi.o_awid    = ID;
    assign axi.o_awaddr  = addr;
    assign axi.o_awlen   = len;
    assign axi.o_awsize  = 3'b011;
    assign axi.o_awburst = 2'b01;
    assign axi.o_awvalid = (state == WR_ADDR);

    // Read data passes straight through while the burst is live, quiet otherwise.
    assign axi.o_rready = (state == RD_DATA) && i_rd_ready;
    assign o_rd_valid   = (state == RD_DATA) && axi.i_rvalid;
    assign o_rd_data    = (state == RD_DATA) ? axi.i_rdata : 64'd0;
    assign o_rd_last    = (state == RD_DATA) && axi.i_rlast;

    // Write data passes straight through; wlast comes from our own beat count.
    assign axi.o_wvalid = (state == WR_DATA) && i_wr_valid;
    assign o_wr_ready   = (state == WR_DATA) && axi.i_wready;
    assign axi.o_wdata  = (state == WR_DATA) ? i_wr_data : 64'd0;
    assign axi.o_wstrb  = (state == WR_DATA) ? 8'hFF : 8'h00;
    assign axi.o_wlast  = (state == WR_DATA) && last_beat;

    assign axi.o_bready = (state == WR_RESP);

    assign o_done = (state == DONE);
    assign o_err  = (state == DONE) && err;

    // Next-state decode; termination keys off the counter, never off rlast.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire) state_nxt = i_cmd_write ? WR_ADDR : RD_ADDR;
            RD_ADDR: if (axi.i_arready) state_nxt = RD_DATA;
            RD_DATA: if (r_fire && last_beat) state_nxt = DONE;
            WR_ADDR: if (axi.i_awready) state_nxt = WR_DATA;
            WR_DATA: if (w_fire && last_beat) state_nxt = WR_RESP;
            WR_RESP: if (b_fire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, command latch, beat counter and sticky error flag.
    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state <= IDLE;
            addr  <= 8'd0;
            len   <= 8'd0;
            cnt   <= 8'd0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_fire) begin
                addr <= i_cmd_addr;
                len  <= i_cmd_len;
                cnt  <= 8'd0;
                err  <= 1'b0;
            end
            if (r_fire) begin
                cnt <= cnt + 8'd1;
                if (axi.i_rresp != 2'b00 || axi.i_rlast != last_beat)
                    err <= 1'b1;
            end
            if (w_fire)
                cnt <= cnt + 8'd1;
            if (b_fire && axi.i_bresp != 2'b00)
                err <= 1'b1;
        end
    end

endmodule
